// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, memory and status signals shared by the data-memory arbiter
interface dmem_arbiter_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [3:0]  cpu_sign_mask;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_stall;

    logic        aux_req;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_we;
    logic [3:0]  aux_sign_mask;
    logic [31:0] aux_rdata;
    logic        aux_done;
    logic        aux_err;
    logic        aux_stall;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        busy;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_sign_mask,
        output cpu_rdata, cpu_done, cpu_err, cpu_stall,
        input  aux_req, aux_addr, aux_wdata, aux_we, aux_sign_mask,
        output aux_rdata, aux_done, aux_err, aux_stall,
        output mem_valid, mem_addr, mem_wdata, mem_we, mem_re, mem_sign_mask,
        input  mem_rdata, mem_ready,
        output busy
    );

    // Requesters plus memory side
    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_sign_mask,
        input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
        output aux_req, aux_addr, aux_wdata, aux_we, aux_sign_mask,
        input  aux_rdata, aux_done, aux_err, aux_stall,
        input  mem_valid, mem_addr, mem_wdata, mem_we, mem_re, mem_sign_mask,
        output mem_rdata, mem_ready,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data-memory arbiter with bounded aux starvation and transaction timeout
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [7:0] LP_TMO   = 8'(TIMEOUT);

    state_t      r_state;
    logic        r_owner;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_mask;
    logic [31:0] r_rdata_q;
    logic        r_err_q;
    logic [7:0]  r_tmo_cnt;
    logic [3:0]  r_streak;

    logic        r_mem_valid;
    logic        r_mem_we;
    logic        r_mem_re;
    logic        r_cpu_done;
    logic        r_cpu_err;
    logic [31:0] r_cpu_rdata;
    logic        r_aux_done;
    logic        r_aux_err;
    logic [31:0] r_aux_rdata;
    logic        r_busy;

    state_t      w_state_nxt;
    logic        w_owner_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic        w_we_nxt;
    logic [3:0]  w_mask_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_err_nxt;
    logic [7:0]  w_tmo_nxt;
    logic [3:0]  w_streak_nxt;
    logic        w_aux_wins;
    logic        w_to_wait;
    logic        w_to_resp;

    // Aux takes the port when the CPU is quiet or has already won STARVE_LIMIT times in a row
    assign w_aux_wins = bus.aux_req & (~bus.cpu_req | (r_streak >= LP_LIMIT));

    // Next-state and next-register computation for the IDLE/WAIT/RESP sequencer
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_we_nxt     = r_we;
        w_mask_nxt   = r_mask;
        w_rdata_nxt  = r_rdata_q;
        w_err_nxt    = r_err_q;
        w_tmo_nxt    = r_tmo_cnt;
        w_streak_nxt = r_streak;
        case (r_state)
            S_IDLE: begin
                if (!bus.aux_req) begin
                    w_streak_nxt = 4'd0;
                end
                if (bus.cpu_req | bus.aux_req) begin
                    w_state_nxt = S_WAIT;
                    w_tmo_nxt   = 8'd0;
                    if (w_aux_wins) begin
                        w_owner_nxt  = 1'b1;
                        w_addr_nxt   = bus.aux_addr;
                        w_wdata_nxt  = bus.aux_wdata;
                        w_we_nxt     = bus.aux_we;
                        w_mask_nxt   = bus.aux_sign_mask;
                        w_streak_nxt = 4'd0;
                    end else begin
                        w_owner_nxt  = 1'b0;
                        w_addr_nxt   = bus.cpu_addr;
                        w_wdata_nxt  = bus.cpu_wdata;
                        w_we_nxt     = bus.cpu_we;
                        w_mask_nxt   = bus.cpu_sign_mask;
                        if (bus.aux_req && (r_streak < LP_LIMIT)) begin
                            w_streak_nxt = r_streak + 4'd1;
                        end
                    end
                end
            end
            S_WAIT: begin
                // A ready arriving on the timeout cycle still counts as a good completion
                if (bus.mem_ready) begin
                    w_rdata_nxt = bus.mem_rdata;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_RESP;
                end else if (r_tmo_cnt == LP_TMO) begin
                    w_rdata_nxt = 32'd0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 8'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_to_wait = (w_state_nxt == S_WAIT);
    assign w_to_resp = (w_state_nxt == S_RESP);

    // State and latched transaction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_we      <= 1'b0;
            r_mask    <= 4'd0;
            r_rdata_q <= 32'd0;
            r_err_q   <= 1'b0;
            r_tmo_cnt <= 8'd0;
            r_streak  <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_we      <= w_we_nxt;
            r_mask    <= w_mask_nxt;
            r_rdata_q <= w_rdata_nxt;
            r_err_q   <= w_err_nxt;
            r_tmo_cnt <= w_tmo_nxt;
            r_streak  <= w_streak_nxt;
        end
    end

    // Output registers decoded from the next state so every output toggles straight off a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= 32'd0;
            r_aux_done  <= 1'b0;
            r_aux_err   <= 1'b0;
            r_aux_rdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_valid <= w_to_wait;
            r_mem_we    <= w_to_wait & w_we_nxt;
            r_mem_re    <= w_to_wait & ~w_we_nxt;
            r_cpu_done  <= w_to_resp & ~w_owner_nxt;
            r_cpu_err   <= w_to_resp & ~w_owner_nxt & w_err_nxt;
            r_cpu_rdata <= (w_to_resp & ~w_owner_nxt) ? w_rdata_nxt : 32'd0;
            r_aux_done  <= w_to_resp & w_owner_nxt;
            r_aux_err   <= w_to_resp & w_owner_nxt & w_err_nxt;
            r_aux_rdata <= (w_to_resp & w_owner_nxt) ? w_rdata_nxt : 32'd0;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.mem_valid     = r_mem_valid;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_re        = r_mem_re;
    assign bus.mem_sign_mask = r_mask;
    assign bus.cpu_done      = r_cpu_done;
    assign bus.cpu_err       = r_cpu_err;
    assign bus.cpu_rdata     = r_cpu_rdata;
    assign bus.aux_done      = r_aux_done;
    assign bus.aux_err       = r_aux_err;
    assign bus.aux_rdata     = r_aux_rdata;
    assign bus.busy          = r_busy;
    assign bus.cpu_stall     = bus.cpu_req & ~r_cpu_done;
    assign bus.aux_stall     = bus.aux_req & ~r_aux_done;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the CPU's data-memory access path (`cpu_*`) and one auxiliary requester (`aux_*`), for example a program loader or debug/DMA engine. The CPU has fixed priority, with a bounded-starvation guarantee for the auxiliary port. The block sits between the requesters and the data memory. It converts each granted request into a `mem_valid`/`mem_ready` transaction that tolerates memory wait states, and it enforces a timeout on each transaction.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum consecutive CPU grants while `aux_req` is pending; range 1..15.
- TIMEOUT, 255: maximum WAIT cycles before a transaction is aborted; range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cpu_req  in  1  CPU access request; held until `cpu_done`.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_sign_mask  in  4  access size and sign mask, passed through unchanged.
- cpu_rdata  out  32  load data; valid while `cpu_done` = 1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies `cpu_done`; 1 = transaction timed out.
- cpu_stall  out  1  combinational: `cpu_req & ~cpu_done`.
- aux_req, aux_addr, aux_wdata, aux_we, aux_sign_mask, aux_rdata, aux_done, aux_err  same directions, widths and meanings as the `cpu_*` ports.
- mem_valid  out  1  memory transaction active.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched store data.
- mem_we  out  1  `mem_valid & latched_we`.
- mem_re  out  1  `mem_valid & ~latched_we`.
- mem_sign_mask  out  4  latched sign mask.
- mem_rdata  in  32  read data; valid when `mem_ready` = 1.
- mem_ready  in  1  completes the current transaction.
- busy  out  1  1 whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - Registers: `owner` (0 = CPU, 1 = aux), latched request fields, `rdata_q`, `err_q`, 8-bit `tmo_cnt`, 4-bit `streak`.
- IDLE:
  - No request: remain in IDLE.
  - Any request: choose the winner, latch addr, wdata, we and sign_mask into the `mem_*` registers, set `owner`, clear `tmo_cnt`, go to WAIT.
- Winner selection: aux wins if `aux_req & (~cpu_req | streak >= STARVE_LIMIT)`; otherwise the CPU wins.
- Streak counter:
  - CPU grant while `aux_req` = 1: `streak++`, saturating at STARVE_LIMIT.
  - Aux grant, or any IDLE cycle with `aux_req` = 0: `streak` clears to 0.
- WAIT:
  - `mem_valid` = 1; all `mem_*` outputs held stable.
  - `mem_ready` = 1: capture `mem_rdata` into `rdata_q`, `err_q` = 0, go to RESP.
  - Otherwise `tmo_cnt++`. When `tmo_cnt` = TIMEOUT and `mem_ready` = 0: `err_q` = 1, `rdata_q` = 0, go to RESP.
  - `mem_ready` arriving in the same cycle as the timeout wins; the transaction completes with no error.
- RESP:
  - Assert the owner's `done`, driving `rdata_q` and `err_q`.
  - The other port's `done`, `err` and `rdata` are all 0.
  - Requests are not sampled in RESP. Next state: IDLE.
- Requester rule: req and all fields are held stable from assertion through the `done` cycle. A new request may be presented in the cycle after `done`.
- `mem_ready` in IDLE or RESP is ignored.
- A store returns `rdata` = `mem_rdata` as captured; consumers ignore it.

## Timing
- Reset values, applied asynchronously on `rst` = 1:
  - state IDLE, `streak` = 0, `tmo_cnt` = 0, `owner` = 0.
  - All outputs 0: every `done`, `err` and `rdata`, `mem_valid`, `mem_we`, `mem_re`, `mem_addr`, `mem_wdata`, `mem_sign_mask`, `busy`.
  - `cpu_stall` follows `cpu_req`.
- Reset during WAIT or RESP abandons the transaction: `mem_valid` drops immediately and no `done` is issued.
- Latency with a zero-wait memory (`mem_ready` in the first WAIT cycle):
  - req sampled in IDLE at cycle 0, WAIT at cycle 1, `done` at cycle 2.
  - Throughput is 1 access per 3 cycles per continuous requester.
- Latency with N wait cycles: `done` at cycle 2 + N.
- Timeout: `done` with `err` at cycle 2 + TIMEOUT.
- All outputs except `cpu_stall` and `aux_stall` are registered.

## Test plan
- Single CPU load: `cpu_addr` = 0x100, memory returns 0xDEADBEEF with 0 wait states -> `mem_re` = 1 and `mem_addr` = 0x100 in cycle 1; `cpu_done` = 1, `cpu_rdata` = 0xDEADBEEF, `cpu_err` = 0 in cycle 2; `aux_done` stays 0.
- Store with 3 wait states: aux store of 0x12345678 to 0x200, sign_mask 0xF -> `mem_we` = 1 and `mem_wdata` stable for 4 cycles; `aux_done` at cycle 5.
- Simultaneous requests: CPU and aux request in the same cycle -> CPU is granted first; aux is granted in the IDLE cycle after the CPU's RESP.
- Starvation bound: STARVE_LIMIT = 4, `cpu_req` held high continuously, `aux_req` high -> exactly 4 CPU grants, then 1 aux grant, then `streak` = 0 and the CPU resumes.
- Timeout: TIMEOUT = 8, `mem_ready` never asserted -> `cpu_done` = 1 and `cpu_err` = 1 at cycle 10 with `cpu_rdata` = 0. Repeat with `mem_ready` asserted exactly in the timeout cycle -> `err` = 0 and data captured.
- Reset mid-WAIT: assert `rst` in cycle 2 of a 5-wait access -> `mem_valid` = 0 immediately and no `done`. After `rst` falls, a fresh request completes normally.
